data_mem_sized: RTL and testbench
=================================

# data_mem_sized

Parametrised successor to the single-cycle word data memory: a byte-addressed data memory for the RISC-V core. It supports RV32I load/store sizes (byte, half, word), sign and zero extension, configurable wait states and a request/response handshake. It sits between the core's MEM stage and the data-memory array, so multi-cycle memory timing can be exercised without changing the core.

## Interface
- ADDR_W, 10, byte-address width; array holds 2^(ADDR_W-2) 32-bit words
- WAIT_CYCLES, 0, extra access cycles inserted before the response (0..15)
- clk  in  1  core clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- req_i  in  1  request valid; sampled only when ready_o=1
- we_i  in  1  1=store, 0=load
- funct3_i  in  3  RV32I size code: 000 b, 001 h, 010 w, 100 bu, 101 hu
- addr_i  in  ADDR_W  byte address
- wdata_i  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- ready_o  out  1  can accept a request this cycle
- rvalid_o  out  1  one-cycle response pulse
- rdata_o  out  32  extended load data; 0 on stores and errors
- err_o  out  1  access fault, valid with rvalid_o

## Operation
- States: IDLE, ACCESS, RESP. ready_o=1 in IDLE and RESP, 0 in ACCESS.
- Accept = req_i & ready_o at a clock edge. On accept, capture addr, we, funct3 and wdata, load wait counter = WAIT_CYCLES, and go to ACCESS.
- ACCESS: while counter≠0, decrement. When counter=0, the next edge is the commit edge:
  - A store writes its enabled byte lanes.
  - rdata_o and err_o are registered.
  - rvalid_o←1 and the state goes to RESP.
- RESP lasts one cycle. An accept in RESP goes directly to ACCESS (back-to-back); otherwise the state goes to IDLE.
- Lane select: word = addr[ADDR_W-1:2].
  - Byte lane = addr[1:0].
  - Half lane = addr[1] (bytes 1:0 or 3:2).
- Store byte enables:
  - sb: one lane, wdata[7:0].
  - sh: two lanes, wdata[15:0].
  - sw: all four lanes.
  - Other lanes are unchanged.
- Loads: lb/lh sign-extend, lbu/lhu zero-extend, lw returns the raw word.
- Illegal funct3 (011, 110, 111, or 100/101 with we=1): err_o=1, no write, rdata_o=0.
- Misaligned access (half with addr[0]=1; word with addr[1:0]≠0): see Configuration.
- The memory array is never reset. Contents are undefined until written.

## Timing
- Reset values: state IDLE, counter 0, ready_o=1, rvalid_o=0, rdata_o=0, err_o=0.
- Latency: accept at edge E0, commit at edge E(WAIT_CYCLES+1), rvalid_o high in the cycle following that edge.
- Throughput: one transaction per WAIT_CYCLES+2 cycles with back-to-back requests.
- Read-after-write to the same word in consecutive transactions returns the new data, because the commit precedes the next access.
- Requests while ready_o=0 are ignored, not queued.
- rst high at any edge abandons the transaction in flight. If rst is high at or before the commit edge, no write occurs and rvalid_o stays 0.

## Configuration
- DMEM_MISALIGN_TRAP_EN defined:
  - Misaligned accesses set err_o=1 with rvalid_o.
  - Stores do not write; loads return rdata_o=0.
- DMEM_MISALIGN_TRAP_EN undefined:
  - Address bits below the access size are ignored (lh at 0x3 acts as 0x2, lw at 0x5 as 0x4) and err_o=0.
  - Illegal-funct3 faults are reported in both builds.

## Test plan
- WAIT_CYCLES=0:
  - sw 0x8000_00F1 to 0x10, then lw 0x10 → rdata 0x8000_00F1.
  - rvalid_o 2 cycles after each accept, err 0.
- After the 0x8000_00F1 store, lb 0x10 → 0xFFFF_FFF1; lbu 0x10 → 0x0000_00F1; lh 0x12 → 0xFFFF_8000; lhu 0x12 → 0x0000_8000.
- sb 0xAB to 0x11 over 0x8000_00F1, then lw 0x10 → 0x8000_ABF1 (other lanes preserved).
- WAIT_CYCLES=3: accept at cycle 0 → rvalid_o in cycle 5 only; ready_o low cycles 1–4; req_i pulsed in cycle 2 is ignored.
- Misaligned and illegal codes:
  - With macro: lw 0x12 → err 1, rdata 0; sh to 0x13 leaves the word unchanged.
  - Without macro: lw 0x12 returns word 0x10.
  - funct3=011 → err 1 in both builds.
- Assert rst during ACCESS of sw 0x1234_5678 to 0x20 → no rvalid_o, ready_o=1 next cycle; lw 0x20 returns the prior contents.

Source files
------------

// File: rtl/data_mem_sized_if.sv
// ---------------------------------------------------------------------------
// data_mem_sized_if
//   Request/response bundle between the core's MEM stage (master) and the
//   sized data memory (slave). The _i/_o suffixes are seen from the memory.
//
//   req_i     master->slave  request valid, sampled only while ready_o=1
//   we_i      master->slave  1=store, 0=load
//   funct3_i  master->slave  RV32I size code (b, h, w, bu, hu)
//   addr_i    master->slave  byte address, ADDR_W bits
//   wdata_i   master->slave  right-aligned store data
//   ready_o   slave->master  a request can be accepted this cycle
//   rvalid_o  slave->master  one-cycle response pulse
//   rdata_o   slave->master  extended load data (0 on stores/faults)
//   err_o     slave->master  access fault, qualified by rvalid_o
// ---------------------------------------------------------------------------
interface data_mem_sized_if #(
  parameter int ADDR_W = 10
);
  logic              req_i;
  logic              we_i;
  logic [2:0]        funct3_i;
  logic [ADDR_W-1:0] addr_i;
  logic [31:0]       wdata_i;
  logic              ready_o;
  logic              rvalid_o;
  logic [31:0]       rdata_o;
  logic              err_o;

  modport master (
    output req_i, we_i, funct3_i, addr_i, wdata_i,
    input  ready_o, rvalid_o, rdata_o, err_o
  );

  modport slave (
    input  req_i, we_i, funct3_i, addr_i, wdata_i,
    output ready_o, rvalid_o, rdata_o, err_o
  );
endinterface

// File: rtl/data_mem_sized.sv
// ---------------------------------------------------------------------------
// data_mem_sized
//   Byte-addressed RV32I data memory with byte/half/word accesses, sign and
//   zero extension, a configurable number of wait states and a
//   request/response handshake. Intended to sit between the core's MEM stage
//   and the data array so multi-cycle memory timing can be exercised.
//
// Parameters
//   ADDR_W       byte-address width; array holds 2^(ADDR_W-2) 32-bit words
//   WAIT_CYCLES  extra access cycles before the response (0..15)
//
// Ports
//   clk   core clock, everything on posedge
//   rst   synchronous, active-high reset (memory contents are not reset)
//   bus   data_mem_sized_if.slave: req/we/funct3/addr/wdata in,
//         ready/rvalid/rdata/err out
//
// Build option
//   DMEM_MISALIGN_TRAP_EN  when defined, misaligned half/word accesses fault
//                          (err_o=1, no write, rdata_o=0). When undefined the
//                          address bits below the access size are ignored.
//                          Illegal funct3 codes fault in both builds.
//
// Timing
//   Accept (req_i & ready_o) at edge E0, commit at edge E(WAIT_CYCLES+1),
//   rvalid_o high for the single cycle after the commit edge. ready_o is
//   high in IDLE and RESP, so a request presented during RESP is taken
//   back-to-back.
// ---------------------------------------------------------------------------
module data_mem_sized #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic            clk,
  input  logic            rst,
  data_mem_sized_if.slave bus
);

  localparam int         DEPTH     = 1 << (ADDR_W - 2);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // Control state
  // -------------------------------------------------------------------------
  state_t     state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;

  logic ready;
  logic accept;
  logic commit;

  assign ready  = (state_reg != ACCESS);
  assign accept = bus.req_i & ready;
  // The edge that ends the last ACCESS cycle is the commit edge.
  assign commit = (state_reg == ACCESS) && (cnt_reg == 4'd0);

  // -------------------------------------------------------------------------
  // Captured request
  // -------------------------------------------------------------------------
  logic              we_reg;
  logic [2:0]        f3_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = ACCESS;
          cnt_next   = WAIT_INIT;
        end
      end
      ACCESS: begin
        if (cnt_reg != 4'd0) begin
          cnt_next = cnt_reg - 4'd1;
        end else begin
          state_next = RESP;
        end
      end
      RESP: begin
        // Back-to-back: a request seen during the response cycle starts the
        // next access immediately.
        if (accept) begin
          state_next = ACCESS;
          cnt_next   = WAIT_INIT;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Request capture
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      we_reg    <= 1'b0;
      f3_reg    <= 3'b000;
      addr_reg  <= '0;
      wdata_reg <= 32'd0;
    end else if (accept) begin
      we_reg    <= bus.we_i;
      f3_reg    <= bus.funct3_i;
      addr_reg  <= bus.addr_i;
      wdata_reg <= bus.wdata_i;
    end
  end

  // -------------------------------------------------------------------------
  // Access decode on the captured request
  // -------------------------------------------------------------------------
  logic                is_byte;
  logic                is_half;
  logic                is_word;
  logic                illegal;
  logic                fault;
  logic [ADDR_W-3:0]   word_idx;
  logic [1:0]          lane;

  assign word_idx = addr_reg[ADDR_W-1:2];
  assign lane     = addr_reg[1:0];
  assign is_byte  = (f3_reg[1:0] == 2'b00);
  assign is_half  = (f3_reg[1:0] == 2'b01);
  assign is_word  = (f3_reg[1:0] == 2'b10);

  // 011/111 have no size; 110 has no unsigned-word form; bu/hu are load-only.
  assign illegal = (f3_reg[1:0] == 2'b11) ||
                   (f3_reg[2] && (f3_reg[1] || we_reg));

`ifdef DMEM_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = (is_half && lane[0]) ||
                      (is_word && (lane != 2'b00));
  assign fault      = illegal | misaligned;
`else
  // Sub-size address bits are simply dropped by the lane selection below.
  assign fault      = illegal;
`endif

  // -------------------------------------------------------------------------
  // Store lane enables and lane-replicated write data
  // -------------------------------------------------------------------------
  logic [3:0]  byte_en;
  logic [31:0] wdata_rep;
  logic [3:0]  lane_we;

  always_comb begin
    byte_en   = 4'b0000;
    wdata_rep = wdata_reg;
    if (is_byte) begin
      byte_en   = 4'b0001 << lane;
      wdata_rep = {4{wdata_reg[7:0]}};
    end else if (is_half) begin
      byte_en   = lane[1] ? 4'b1100 : 4'b0011;
      wdata_rep = {2{wdata_reg[15:0]}};
    end else if (is_word) begin
      byte_en   = 4'b1111;
      wdata_rep = wdata_reg;
    end
  end

  // A lane is written only on the commit edge of a legal store.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane_we
    assign lane_we[gi] = commit & we_reg & ~fault & byte_en[gi];
  end

  // -------------------------------------------------------------------------
  // Memory array: byte-lane writes, registered read. No reset on contents.
  // A reset asserted on the commit edge suppresses the write.
  // -------------------------------------------------------------------------
  logic [31:0] mem_array [DEPTH];
  logic [31:0] raw_reg;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (lane_we[i] && !rst) begin
        mem_array[word_idx][8*i +: 8] <= wdata_rep[8*i +: 8];
      end
    end
    if (commit && !rst) begin
      raw_reg <= mem_array[word_idx];
    end
  end

  // -------------------------------------------------------------------------
  // Response registers
  // -------------------------------------------------------------------------
  logic       rvalid_reg;
  logic       err_reg;
  logic       resp_load_reg;  // response carries load data
  logic [2:0] resp_f3_reg;
  logic [1:0] resp_lane_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_reg    <= 1'b0;
      err_reg       <= 1'b0;
      resp_load_reg <= 1'b0;
      resp_f3_reg   <= 3'b000;
      resp_lane_reg <= 2'b00;
    end else if (commit) begin
      rvalid_reg    <= 1'b1;
      err_reg       <= fault;
      resp_load_reg <= ~we_reg & ~fault;
      resp_f3_reg   <= f3_reg;
      resp_lane_reg <= lane;
    end else begin
      rvalid_reg    <= 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Load extraction and extension. Uses only response-side registers so the
  // value stays stable while the next request is being captured.
  // -------------------------------------------------------------------------
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] rdata_ext;
  logic [31:0] rdata_out;

  always_comb begin
    byte_sel  = 8'(raw_reg >> {resp_lane_reg, 3'b000});
    half_sel  = resp_lane_reg[1] ? raw_reg[31:16] : raw_reg[15:0];
    rdata_ext = raw_reg;
    case (resp_f3_reg)
      3'b000:  rdata_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  rdata_ext = {24'd0, byte_sel};
      3'b001:  rdata_ext = {{16{half_sel[15]}}, half_sel};
      3'b101:  rdata_ext = {16'd0, half_sel};
      default: rdata_ext = raw_reg;
    endcase
    rdata_out = resp_load_reg ? rdata_ext : 32'd0;
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.ready_o  = ready;
  assign bus.rvalid_o = rvalid_reg;
  assign bus.rdata_o  = rdata_out;
  assign bus.err_o    = err_reg;

endmodule

// File: tb/tb_data_mem_sized.sv
// ---------------------------------------------------------------------------
// tb_data_mem_sized
//   Two instances: dut0 with WAIT_CYCLES=0 runs a table of directed
//   load/store vectors plus a back-to-back sequence; dut1 with WAIT_CYCLES=3
//   checks cycle-exact handshake timing, ignored requests and reset abort.
// ---------------------------------------------------------------------------
module tb_data_mem_sized;

  localparam int AW = 10;

`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_mem_sized_if #(.ADDR_W(AW)) bus0 ();
  data_mem_sized_if #(.ADDR_W(AW)) bus1 ();

  data_mem_sized #(.ADDR_W(AW), .WAIT_CYCLES(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  data_mem_sized #(.ADDR_W(AW), .WAIT_CYCLES(3)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------
  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input string name, input logic we, input logic [2:0] f3,
                              input logic [9:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.name = name; v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    vecs.push_back(v);
  endfunction

  // One transaction on dut0; returns the response and cycles from accept
  // edge to the rvalid cycle (40 = timeout).
  task automatic txn0(input logic we, input logic [2:0] f3, input logic [9:0] addr,
                      input logic [31:0] wdata, output logic [31:0] rdata,
                      output logic err, output int lat);
    int n;
    @(negedge clk);
    n = 0;
    while (!bus0.ready_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    bus0.req_i = 1'b1; bus0.we_i = we; bus0.funct3_i = f3;
    bus0.addr_i = addr; bus0.wdata_i = wdata;
    @(posedge clk);
    @(negedge clk);
    bus0.req_i = 1'b0;
    lat = 1;
    while (!bus0.rvalid_o && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rdata = bus0.rdata_o;
    err   = bus0.err_o;
  endtask

  // Cycle-exact transaction on dut1 (WAIT_CYCLES=3). The request is driven in
  // cycle 0; in cycle 2 a store of 0xDEADBEEF to 0x20 is pulsed, which must
  // be ignored because ready_o is low.
  task automatic txn1(input string name, input logic we, input logic [2:0] f3,
                      input logic [9:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata);
    @(negedge clk);
    bus1.req_i = 1'b1; bus1.we_i = we; bus1.funct3_i = f3;
    bus1.addr_i = addr; bus1.wdata_i = wdata;
    @(negedge clk);
    bus1.req_i = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      check($sformatf("%s ready c%0d", name, c), 32'(bus1.ready_o),
            (c >= 1 && c <= 4) ? 32'd0 : 32'd1);
      check($sformatf("%s rvalid c%0d", name, c), 32'(bus1.rvalid_o),
            (c == 5) ? 32'd1 : 32'd0);
      if (c == 5) begin
        check($sformatf("%s rdata", name), bus1.rdata_o, exp_rdata);
        check($sformatf("%s err", name), 32'(bus1.err_o), 32'd0);
      end
      if (c == 2) begin
        bus1.req_i = 1'b1; bus1.we_i = 1'b1; bus1.funct3_i = 3'b010;
        bus1.addr_i = 10'h020; bus1.wdata_i = 32'hDEAD_BEEF;
      end
      if (c == 3) bus1.req_i = 1'b0;
      if (c < 6) @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [31:0] w10_after_sh;
    logic [31:0] lh11_exp;
    int          seen;

    bus0.req_i = 1'b0; bus0.we_i = 1'b0; bus0.funct3_i = 3'b000;
    bus0.addr_i = '0; bus0.wdata_i = 32'd0;
    bus1.req_i = 1'b0; bus1.we_i = 1'b0; bus1.funct3_i = 3'b000;
    bus1.addr_i = '0; bus1.wdata_i = 32'd0;
    rst = 1'b1;
    repeat (3) @(negedge clk);

    check("reset ready0",  32'(bus0.ready_o),  32'd1);
    check("reset rvalid0", 32'(bus0.rvalid_o), 32'd0);
    check("reset rdata0",  bus0.rdata_o,       32'd0);
    check("reset err0",    32'(bus0.err_o),    32'd0);
    check("reset ready1",  32'(bus1.ready_o),  32'd1);
    check("reset rvalid1", 32'(bus1.rvalid_o), 32'd0);
    rst = 1'b0;

    // Expected values that depend on the misalignment build option.
    w10_after_sh = MIS ? 32'h8000_ABF1 : 32'h5555_ABF1;
    lh11_exp     = MIS ? 32'h0000_0000 : 32'hFFFF_ABF1;

    add("sw 10",        1, 3'b010, 10'h010, 32'h8000_00F1, 32'h0000_0000, 0);
    add("lw 10",        0, 3'b010, 10'h010, 32'h0,         32'h8000_00F1, 0);
    add("lb 10",        0, 3'b000, 10'h010, 32'h0,         32'hFFFF_FFF1, 0);
    add("lbu 10",       0, 3'b100, 10'h010, 32'h0,         32'h0000_00F1, 0);
    add("lh 12",        0, 3'b001, 10'h012, 32'h0,         32'hFFFF_8000, 0);
    add("lhu 12",       0, 3'b101, 10'h012, 32'h0,         32'h0000_8000, 0);
    add("sb 11",        1, 3'b000, 10'h011, 32'hFFFF_FFAB, 32'h0000_0000, 0);
    add("lw 10 post sb",0, 3'b010, 10'h010, 32'h0,         32'h8000_ABF1, 0);
    add("lw 12 misal",  0, 3'b010, 10'h012, 32'h0,         MIS ? 32'h0 : 32'h8000_ABF1, MIS);
    add("sh 13 misal",  1, 3'b001, 10'h013, 32'h0000_5555, 32'h0000_0000, MIS);
    add("lw 10 post sh",0, 3'b010, 10'h010, 32'h0,         w10_after_sh, 0);
    add("ld f3=011",    0, 3'b011, 10'h010, 32'h0,         32'h0000_0000, 1);
    add("st f3=011",    1, 3'b011, 10'h010, 32'h0,         32'h0000_0000, 1);
    add("st f3=100",    1, 3'b100, 10'h010, 32'h0,         32'h0000_0000, 1);
    add("st f3=101",    1, 3'b101, 10'h010, 32'h0,         32'h0000_0000, 1);
    add("ld f3=110",    0, 3'b110, 10'h010, 32'h0,         32'h0000_0000, 1);
    add("ld f3=111",    0, 3'b111, 10'h010, 32'h0,         32'h0000_0000, 1);
    add("lw 10 intact", 0, 3'b010, 10'h010, 32'h0,         w10_after_sh, 0);
    add("sw 14",        1, 3'b010, 10'h014, 32'h1122_3344, 32'h0000_0000, 0);
    add("sh 16",        1, 3'b001, 10'h016, 32'hFFFF_BEEF, 32'h0000_0000, 0);
    add("lw 14",        0, 3'b010, 10'h014, 32'h0,         32'hBEEF_3344, 0);
    add("lh 16",        0, 3'b001, 10'h016, 32'h0,         32'hFFFF_BEEF, 0);
    add("lb 17",        0, 3'b000, 10'h017, 32'h0,         32'hFFFF_FFBE, 0);
    add("lbu 15",       0, 3'b100, 10'h015, 32'h0,         32'h0000_0033, 0);
    add("lhu 14",       0, 3'b101, 10'h014, 32'h0,         32'h0000_3344, 0);
    add("lb 14",        0, 3'b000, 10'h014, 32'h0,         32'h0000_0044, 0);
    add("lw 15 misal",  0, 3'b010, 10'h015, 32'h0,         MIS ? 32'h0 : 32'hBEEF_3344, MIS);
    add("lh 11 misal",  0, 3'b001, 10'h011, 32'h0,         lh11_exp, MIS);
    add("sw 3FC",       1, 3'b010, 10'h3FC, 32'hA5A5_5A5A, 32'h0000_0000, 0);
    add("lw 3FC",       0, 3'b010, 10'h3FC, 32'h0,         32'hA5A5_5A5A, 0);
    add("lw 14 top ok", 0, 3'b010, 10'h014, 32'h0,         32'hBEEF_3344, 0);

    foreach (vecs[i]) begin
      txn0(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, er, lat);
      check({vecs[i].name, " rdata"}, rd, vecs[i].exp_rdata);
      check({vecs[i].name, " err"}, 32'(er), 32'(vecs[i].exp_err));
      check({vecs[i].name, " latency"}, 32'(lat), 32'd2);
      $display("txn %0d %s: we=%0d f3=%03b addr=0x%03h rdata=0x%08h err=%0d lat=%0d",
               i, vecs[i].name, vecs[i].we, vecs[i].f3, vecs[i].addr, rd, er, lat);
    end

    // Back-to-back on dut0: request held through RESP is accepted at once.
    @(negedge clk);
    bus0.req_i = 1'b1; bus0.we_i = 1'b0; bus0.funct3_i = 3'b010;
    bus0.addr_i = 10'h010; bus0.wdata_i = 32'd0;
    @(negedge clk);  // cycle 1: ACCESS
    check("b2b c1 ready",  32'(bus0.ready_o),  32'd0);
    check("b2b c1 rvalid", 32'(bus0.rvalid_o), 32'd0);
    @(negedge clk);  // cycle 2: RESP for first
    check("b2b c2 rvalid", 32'(bus0.rvalid_o), 32'd1);
    check("b2b c2 rdata",  bus0.rdata_o,       w10_after_sh);
    bus0.addr_i = 10'h014;
    @(negedge clk);  // cycle 3: ACCESS for second
    bus0.req_i = 1'b0;
    check("b2b c3 ready",  32'(bus0.ready_o),  32'd0);
    check("b2b c3 rvalid", 32'(bus0.rvalid_o), 32'd0);
    @(negedge clk);  // cycle 4: RESP for second
    check("b2b c4 rvalid", 32'(bus0.rvalid_o), 32'd1);
    check("b2b c4 rdata",  bus0.rdata_o,       32'hBEEF_3344);
    $display("txn b2b: lw 0x010 then lw 0x014 back-to-back");

    // WAIT_CYCLES=3 timing on dut1.
    txn1("w3 sw 20", 1'b1, 3'b010, 10'h020, 32'hCAFE_F00D, 32'h0000_0000);
    $display("txn w3: sw 0x020 0xCAFEF00D with ignored pulse");
    txn1("w3 lw 20", 1'b0, 3'b010, 10'h020, 32'h0,         32'hCAFE_F00D);
    $display("txn w3: lw 0x020 expect 0xCAFEF00D");

    // Reset during ACCESS abandons the store.
    @(negedge clk);
    bus1.req_i = 1'b1; bus1.we_i = 1'b1; bus1.funct3_i = 3'b010;
    bus1.addr_i = 10'h020; bus1.wdata_i = 32'h1234_5678;
    @(negedge clk);  // cycle 1
    bus1.req_i = 1'b0;
    @(negedge clk);  // cycle 2
    rst = 1'b1;
    @(negedge clk);  // cycle 3, after reset edge
    rst = 1'b0;
    check("rst abort ready",  32'(bus1.ready_o),  32'd1);
    check("rst abort rvalid", 32'(bus1.rvalid_o), 32'd0);
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus1.rvalid_o) seen++;
    end
    check("rst abort no rvalid", 32'(seen), 32'd0);
    $display("txn rst: sw 0x020 0x12345678 abandoned by reset");
    txn1("post rst lw 20", 1'b0, 3'b010, 10'h020, 32'h0, 32'hCAFE_F00D);
    $display("txn rst: lw 0x020 expect prior contents 0xCAFEF00D");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
